// File: rtl/data_memory_pkg.sv
// Shared types and default sizing for the datapath data memory.
// The controller FSM has two states: clear sweep and normal service.
package data_memory_pkg;

    localparam int DEFAULT_DW    = 4;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/data_memory_array.sv
// DEPTH x DW storage with one write port and one registered read port.
// The storage has no reset; only the read register does.
module data_memory_array
    import data_memory_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          rzero,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rzero forces a zero result for addresses with no backing word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: clear sweep after reset or clr, valid/ready request port,
// 1-cycle registered read, and an out-of-range address flag.
//  state   | meaning
//  ST_INIT | writing INIT_VALUE to every word, requests blocked
//  ST_RUN  | serving requests; clr restarts the sweep
module data_memory_ctrl
    import data_memory_pkg::*;
#(
    parameter int              DW         = DEFAULT_DW,
    parameter int              DEPTH      = DEFAULT_DEPTH,
    parameter int              AW         = $clog2(DEPTH),
    parameter logic [DW-1:0]   INIT_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          addr_err,
    output logic          init_busy
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    state_t        state;
    logic [AW-1:0] init_ptr;
    logic          accept;
    logic          in_range;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    assign req_ready = (state == ST_RUN) && !clr;
    assign init_busy = (state == ST_INIT);
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < DEPTH_W;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = req_addr;
        mem_wdata = req_wdata;
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_ptr;
            mem_wdata = INIT_VALUE;
        end else begin
            mem_we = accept && req_write && in_range;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_INIT;
            init_ptr <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_ptr == LAST_PTR) begin
                        state    <= ST_RUN;
                        init_ptr <= '0;
                    end else begin
                        init_ptr <= init_ptr + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        state    <= ST_INIT;
                        init_ptr <= '0;
                    end
                end
                default: begin
                    state    <= ST_INIT;
                    init_ptr <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= accept && !req_write;
            addr_err <= accept && !in_range;
        end
    end

    data_memory_array #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (accept && !req_write),
        .raddr (req_addr),
        .rzero (!in_range),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a DEPTH=16 and a DEPTH=12 instance checked every cycle
// against an array-based model of the memory and its clear sweep.
module tb_data_memory_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       valid [2];
    logic       write [2];
    logic       clr   [2];
    logic [3:0] addr  [2];
    logic [3:0] wdata [2];
    logic       ready [2];
    logic       rdv   [2];
    logic       aerr  [2];
    logic       busy  [2];
    logic [3:0] rdd   [2];

    data_memory_ctrl #(.DW(4), .DEPTH(16)) dut16 (
        .clk(clk), .rst(rst), .clr(clr[0]), .req_valid(valid[0]), .req_ready(ready[0]),
        .req_write(write[0]), .req_addr(addr[0]), .req_wdata(wdata[0]),
        .rd_valid(rdv[0]), .rd_data(rdd[0]), .addr_err(aerr[0]), .init_busy(busy[0])
    );

    data_memory_ctrl #(.DW(4), .DEPTH(12)) dut12 (
        .clk(clk), .rst(rst), .clr(clr[1]), .req_valid(valid[1]), .req_ready(ready[1]),
        .req_write(write[1]), .req_addr(addr[1]), .req_wdata(wdata[1]),
        .rd_valid(rdv[1]), .rd_data(rdd[1]), .addr_err(aerr[1]), .init_busy(busy[1])
    );

    // reference model: word contents, remaining clear cycles, expected outputs
    logic [3:0] mm [2][16];
    int         init_left [2];
    logic       e_rv [2];
    logic       e_ae [2];
    logic [3:0] e_rd [2];
    logic       e_ready [2];
    logic       o_ready [2];

    int vectors = 0;
    int miscompares = 0;

    function automatic int depth_of(int i);
        return (i == 0) ? 16 : 12;
    endfunction

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; write[i] = 1'b0; clr[i] = 1'b0;
            addr[i] = 4'h0; wdata[i] = 4'h0;
        end
    endtask

    task automatic drive(input int i, input logic v, input logic w,
                         input logic [3:0] a, input logic [3:0] d, input logic c);
        valid[i] = v; write[i] = w; addr[i] = a; wdata[i] = d; clr[i] = c;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            init_left[i] = depth_of(i);
            e_rv[i] = 1'b0; e_ae[i] = 1'b0; e_rd[i] = 4'h0;
        end
    endtask

    task automatic model_edge(input int i);
        int  dp;
        bit  oob;
        dp = depth_of(i);
        if (init_left[i] > 0) begin
            mm[i][dp - init_left[i]] = 4'h0;
            init_left[i]--;
            e_rv[i] = 1'b0; e_ae[i] = 1'b0;
        end else if (clr[i]) begin
            init_left[i] = dp;
            e_rv[i] = 1'b0; e_ae[i] = 1'b0;
        end else if (valid[i]) begin
            oob = int'(addr[i]) >= dp;
            e_ae[i] = oob;
            if (write[i]) begin
                e_rv[i] = 1'b0;
                if (!oob) mm[i][addr[i]] = wdata[i];
            end else begin
                e_rv[i] = 1'b1;
                e_rd[i] = oob ? 4'h0 : mm[i][addr[i]];
            end
        end else begin
            e_rv[i] = 1'b0; e_ae[i] = 1'b0;
        end
    endtask

    // samples ready before the edge, advances one clock and the model, returns idle
    task automatic tick();
        #2;
        for (int i = 0; i < 2; i++) begin
            o_ready[i] = ready[i];
            e_ready[i] = (init_left[i] == 0) && !clr[i];
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i);
        #1;
        idle_all();
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({ready[i], rdv[i], rdd[i], aerr[i], busy[i]} !== {1'b0, 1'b0, 4'h0, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL reset_hold inst%0d: got rdy=%b vld=%b data=%h err=%b busy=%b, want 0 0 0 0 1",
                         i, ready[i], rdv[i], rdd[i], aerr[i], busy[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 17; n++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if ({o_ready[i], rdv[i], rdd[i], aerr[i], busy[i]} !==
                    {e_ready[i], e_rv[i], e_rd[i], e_ae[i], init_left[i] != 0}) begin
                    miscompares++;
                    $display("FAIL init_sweep inst%0d cyc%0d: got rdy=%b vld=%b data=%h err=%b busy=%b, want rdy=%b vld=%b data=%h err=%b busy=%b",
                             i, n, o_ready[i], rdv[i], rdd[i], aerr[i], busy[i],
                             e_ready[i], e_rv[i], e_rd[i], e_ae[i], init_left[i] != 0);
                end
            end
        end
        // exactly DEPTH busy cycles for the 16-word instance
        vectors++;
        if (busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL init_length: got busy=%b after 17 cycles, want 0", busy[0]);
        end
    endtask

    task automatic test_read_all(input string name);
        for (int a = 0; a < 16; a++) begin
            drive(0, 1'b1, 1'b0, 4'(a), 4'h0, 1'b0);
            if (a < 12) drive(1, 1'b1, 1'b0, 4'(a), 4'h0, 1'b0);
            tick();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if ({o_ready[i], rdv[i], rdd[i], aerr[i], busy[i]} !==
                    {e_ready[i], e_rv[i], e_rd[i], e_ae[i], init_left[i] != 0}) begin
                    miscompares++;
                    $display("FAIL %s inst%0d addr%0d: got rdy=%b vld=%b data=%h err=%b busy=%b, want rdy=%b vld=%b data=%h err=%b busy=%b",
                             name, i, a, o_ready[i], rdv[i], rdd[i], aerr[i], busy[i],
                             e_ready[i], e_rv[i], e_rd[i], e_ae[i], init_left[i] != 0);
                end
            end
        end
    endtask

    task automatic test_write_read();
        drive(0, 1'b1, 1'b1, 4'd3, 4'hA, 1'b0);
        tick();
        drive(0, 1'b1, 1'b0, 4'd3, 4'h0, 1'b0);
        tick();
        vectors++;
        if ({rdv[0], rdd[0], aerr[0]} !== {1'b1, 4'hA, 1'b0}) begin
            miscompares++;
            $display("FAIL write_then_read: got vld=%b data=%h err=%b, want 1 a 0", rdv[0], rdd[0], aerr[0]);
        end
        tick();
        vectors++;
        if ({rdv[0], rdd[0]} !== {1'b0, 4'hA}) begin
            miscompares++;
            $display("FAIL read_hold: got vld=%b data=%h, want 0 a", rdv[0], rdd[0]);
        end
    endtask

    task automatic test_stream();
        for (int a = 0; a < 16; a++) begin
            drive(0, 1'b1, 1'b1, 4'(a), 4'($urandom_range(0, 15)), 1'b0);
            tick();
        end
        for (int a = 0; a < 16; a++) begin
            drive(0, 1'b1, 1'b0, 4'(a), 4'h0, 1'b0);
            tick();
            vectors++;
            if ({o_ready[0], rdv[0], rdd[0], aerr[0]} !== {1'b1, 1'b1, mm[0][a], 1'b0}) begin
                miscompares++;
                $display("FAIL stream addr%0d: got rdy=%b vld=%b data=%h err=%b, want 1 1 %h 0",
                         a, o_ready[0], rdv[0], rdd[0], aerr[0], mm[0][a]);
            end
        end
    endtask

    task automatic test_out_of_range();
        drive(1, 1'b1, 1'b1, 4'd13, 4'h5, 1'b0);
        tick();
        vectors++;
        if ({rdv[1], aerr[1]} !== {1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL oob_write: got vld=%b err=%b, want 0 1", rdv[1], aerr[1]);
        end
        drive(1, 1'b1, 1'b0, 4'd13, 4'h0, 1'b0);
        tick();
        vectors++;
        if ({rdv[1], rdd[1], aerr[1]} !== {1'b1, 4'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL oob_read: got vld=%b data=%h err=%b, want 1 0 1", rdv[1], rdd[1], aerr[1]);
        end
        tick();
        vectors++;
        if (aerr[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL oob_pulse: got err=%b one cycle later, want 0", aerr[1]);
        end
        test_read_all("oob_unchanged");
    endtask

    task automatic test_clr();
        drive(0, 1'b1, 1'b1, 4'd7, 4'hF, 1'b0);
        tick();
        drive(0, 1'b1, 1'b0, 4'd7, 4'h0, 1'b1);
        tick();
        vectors++;
        if ({o_ready[0], rdv[0], busy[0]} !== {1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL clr_blocks: got rdy=%b vld=%b busy=%b, want 0 0 1", o_ready[0], rdv[0], busy[0]);
        end
        for (int n = 0; n < 16; n++) begin
            tick();
            vectors++;
            if ({o_ready[0], busy[0]} !== {1'b0, init_left[0] != 0}) begin
                miscompares++;
                $display("FAIL clr_sweep cyc%0d: got rdy=%b busy=%b, want 0 %b",
                         n, o_ready[0], busy[0], init_left[0] != 0);
            end
        end
        drive(0, 1'b1, 1'b0, 4'd7, 4'h0, 1'b0);
        tick();
        vectors++;
        if ({rdv[0], rdd[0]} !== {1'b1, 4'h0}) begin
            miscompares++;
            $display("FAIL clr_cleared: got vld=%b data=%h, want 1 0", rdv[0], rdd[0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                drive(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      $urandom_range(0, 59) == 0);
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if ({o_ready[i], rdv[i], rdd[i], aerr[i], busy[i]} !==
                    {e_ready[i], e_rv[i], e_rd[i], e_ae[i], init_left[i] != 0}) begin
                    miscompares++;
                    $display("FAIL random inst%0d cyc%0d: got rdy=%b vld=%b data=%h err=%b busy=%b, want rdy=%b vld=%b data=%h err=%b busy=%b",
                             i, n, o_ready[i], rdv[i], rdd[i], aerr[i], busy[i],
                             e_ready[i], e_rv[i], e_rd[i], e_ae[i], init_left[i] != 0);
                end
            end
        end
    endtask

    task automatic test_reset_abort(input int cycles_before, input logic reading);
        for (int n = 0; n < cycles_before; n++) begin
            if (reading) drive(0, 1'b1, 1'b0, 4'(n), 4'h0, 1'b0);
            tick();
        end
        if (reading) drive(0, 1'b1, 1'b0, 4'd9, 4'h0, 1'b0);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({ready[i], rdv[i], rdd[i], aerr[i], busy[i]} !== {1'b0, 1'b0, 4'h0, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL abort_%s inst%0d: got rdy=%b vld=%b data=%h err=%b busy=%b, want 0 0 0 0 1",
                         reading ? "read" : "init", i, ready[i], rdv[i], rdd[i], aerr[i], busy[i]);
            end
        end
        idle_all();
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 16; n++) begin
            tick();
            vectors++;
            if (busy[0] !== (n < 15)) begin
                miscompares++;
                $display("FAIL abort_restart cyc%0d: got busy=%b, want %b", n, busy[0], n < 15);
            end
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_read_all("init_zero");
        test_write_read();
        test_stream();
        test_out_of_range();
        test_clr();
        test_random();
        test_reset_abort(8, 1'b0);
        test_read_all("after_init_abort");
        test_reset_abort(5, 1'b1);
        test_read_all("after_read_abort");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
